fifo_rd_arbiter: RTL



---
 rtl/fifo_rd_arbiter.sv | 116 +++++++++++
 1 files changed

// File: rtl/fifo_rd_arbiter.sv
// Round-robin read arbiter for two FWFT FIFOs: grants a burst when a FIFO holds a
// full burst (or any data while flushing), requests it downstream, then streams it.
module fifo_rd_arbiter #(
  parameter int RD_WIDTH        = 32,
  parameter int RD_CNT_WIDTH    = 11,
  parameter int BURST_LEN       = 16,
  parameter int BURST_CNT_WIDTH = 5
) (
  input  logic                       rd_clk,
  input  logic                       rd_rst,
  input  logic [RD_CNT_WIDTH-1:0]    fifo0_rd_data_count,
  input  logic [RD_CNT_WIDTH-1:0]    fifo1_rd_data_count,
  input  logic                       fifo0_empty,
  input  logic                       fifo1_empty,
  input  logic [RD_WIDTH-1:0]        fifo0_rd_data,
  input  logic [RD_WIDTH-1:0]        fifo1_rd_data,
  output logic                       fifo0_rd_en,
  output logic                       fifo1_rd_en,
  input  logic                       flush,
  output logic                       burst_req,
  output logic                       burst_ch,
  output logic [BURST_CNT_WIDTH-1:0] burst_len,
  input  logic                       burst_ack,
  output logic                       out_valid,
  output logic [RD_WIDTH-1:0]        out_data,
  output logic                       out_last,
  input  logic                       out_ready,
  output logic                       busy
);

  typedef enum logic [1:0] {IDLE, REQ, DATA} state_t;

  localparam logic [RD_CNT_WIDTH-1:0]    BURST_LEN_CNT   = RD_CNT_WIDTH'(BURST_LEN);
  localparam logic [BURST_CNT_WIDTH-1:0] BURST_LEN_BEATS = BURST_CNT_WIDTH'(BURST_LEN);
  localparam logic [BURST_CNT_WIDTH-1:0] ONE_BEAT        = BURST_CNT_WIDTH'(1);

  state_t                     state_q, state_d;
  logic                       last_grant_q, last_grant_d;
  logic                       grant_q, grant_d;
  logic [BURST_CNT_WIDTH-1:0] len_q, len_d;
  logic [BURST_CNT_WIDTH-1:0] beat_q, beat_d;

  logic elig0, elig1;
  logic sel_empty;
  logic beat_hs;

  // Burst length is the occupancy clipped to a full burst.
  function automatic logic [BURST_CNT_WIDTH-1:0] clip_len(input logic [RD_CNT_WIDTH-1:0] cnt);
    if (cnt >= BURST_LEN_CNT) return BURST_LEN_BEATS;
    return BURST_CNT_WIDTH'(cnt);
  endfunction

  assign elig0 = (fifo0_rd_data_count >= BURST_LEN_CNT) || (flush && (fifo0_rd_data_count != '0));
  assign elig1 = (fifo1_rd_data_count >= BURST_LEN_CNT) || (flush && (fifo1_rd_data_count != '0));

  assign sel_empty   = grant_q ? fifo1_empty : fifo0_empty;
  assign out_data    = grant_q ? fifo1_rd_data : fifo0_rd_data;
  assign out_valid   = (state_q == DATA) && !sel_empty;
  assign beat_hs     = out_valid && out_ready;
  assign fifo0_rd_en = beat_hs && !grant_q;
  assign fifo1_rd_en = beat_hs && grant_q;
  assign out_last    = out_valid && (beat_q == ONE_BEAT);
  assign burst_req   = (state_q == REQ);
  assign burst_ch    = grant_q;
  assign burst_len   = len_q;
  assign busy        = (state_q != IDLE);

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    len_d        = len_q;
    beat_d       = beat_q;
    case (state_q)
      IDLE: begin
        if (elig0 || elig1) begin
          grant_d = (elig0 && elig1) ? !last_grant_q : elig1;
          len_d   = clip_len(grant_d ? fifo1_rd_data_count : fifo0_rd_data_count);
          beat_d  = len_d;
          state_d = REQ;
        end
      end
      REQ: begin
        if (burst_ack) state_d = DATA;
      end
      DATA: begin
        if (beat_hs) begin
          beat_d = beat_q - ONE_BEAT;
          if (beat_q == ONE_BEAT) begin
            state_d      = IDLE;
            last_grant_d = grant_q;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Reset favours channel 0 on the first tie by pretending channel 1 went last.
  always_ff @(posedge rd_clk) begin
    if (rd_rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      grant_q      <= 1'b0;
      len_q        <= '0;
      beat_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      len_q        <= len_d;
      beat_q       <= beat_d;
    end
  end

endmodule
